// File: rtl/bist_pkg.sv
// Shared definitions for the March BIST controller: FSM states and the
// fixed five-element March table (one bit per element, indexed by element).
package bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    localparam int NUM_ELEM = 5;
    localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

    // Bit i describes element Ei.
    // E0 up w0 | E1 up r0,w1 | E2 up r1,w0 | E3 down r0,w1 | E4 down r1,w0
    localparam logic [NUM_ELEM-1:0] ELEM_UP       = 5'b00111;
    localparam logic [NUM_ELEM-1:0] ELEM_HAS_READ = 5'b11110;
    localparam logic [NUM_ELEM-1:0] ELEM_RD_VAL   = 5'b10100;
    localparam logic [NUM_ELEM-1:0] ELEM_WR_VAL   = 5'b01010;

endpackage

// File: rtl/bist_control_if.sv
// Control/status bundle between the BIST sequencer and its environment
// (start request, address counter, memory strobes).
interface bist_control_if;
    logic start;
    logic c_out;
    logic status;
    logic done;
    logic wr_en;
    logic read_en;
    logic rst_adr;
    logic pr_res_adr;
    logic enable;
    logic up_down;
    logic data_bit;

    // Sequencer side.
    modport master (
        input  start, c_out,
        output status, done, wr_en, read_en, rst_adr, pr_res_adr,
               enable, up_down, data_bit
    );

    // Environment side (start source, address counter, memory).
    modport slave (
        output start, c_out,
        input  status, done, wr_en, read_en, rst_adr, pr_res_adr,
               enable, up_down, data_bit
    );
endinterface

// File: rtl/bist_control.sv
// Moore FSM sequencing a 5-element March test. Outputs decode only from the
// registered state and element index, so there is no input-to-output path.
module bist_control
    import bist_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    bist_control_if.master  bus
);

    state_t     state_q, state_d;
    logic [2:0] elem_q,  elem_d;

    logic status_o, done_o, wr_en_o, read_en_o, rst_adr_o, pr_res_adr_o;
    logic enable_o, up_down_o, data_bit_o;

    // State and element index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            elem_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
        end
    end

    // Next state: elements advance only on terminal count seen during a write.
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_SETUP;
                    elem_d  = 3'd0;
                end
            end
            S_SETUP: state_d = ELEM_HAS_READ[elem_q] ? S_RD : S_WR;
            S_RD:    state_d = S_WR;
            S_WR: begin
                if (bus.c_out) begin
                    if (elem_q == LAST_ELEM) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETUP;
                        elem_d  = elem_q + 3'd1;
                    end
                end else if (ELEM_HAS_READ[elem_q]) begin
                    state_d = S_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state/element only.
    always_comb begin
        status_o     = 1'b0;
        done_o       = 1'b0;
        wr_en_o      = 1'b0;
        read_en_o    = 1'b0;
        rst_adr_o    = 1'b0;
        pr_res_adr_o = 1'b0;
        enable_o     = 1'b0;
        up_down_o    = 1'b0;
        data_bit_o   = 1'b0;
        case (state_q)
            S_SETUP: begin
                status_o     = 1'b1;
                up_down_o    = ELEM_UP[elem_q];
                rst_adr_o    = ELEM_UP[elem_q];
                pr_res_adr_o = ~ELEM_UP[elem_q];
            end
            S_RD: begin
                status_o   = 1'b1;
                read_en_o  = 1'b1;
                up_down_o  = ELEM_UP[elem_q];
                data_bit_o = ELEM_RD_VAL[elem_q];
            end
            S_WR: begin
                status_o   = 1'b1;
                wr_en_o    = 1'b1;
                enable_o   = 1'b1;
                up_down_o  = ELEM_UP[elem_q];
                data_bit_o = ELEM_WR_VAL[elem_q];
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.status     = status_o;
    assign bus.done       = done_o;
    assign bus.wr_en      = wr_en_o;
    assign bus.read_en    = read_en_o;
    assign bus.rst_adr    = rst_adr_o;
    assign bus.pr_res_adr = pr_res_adr_o;
    assign bus.enable     = enable_o;
    assign bus.up_down    = up_down_o;
    assign bus.data_bit   = data_bit_o;

endmodule

// File: tb/tb_bist_control.sv
// Scoreboard bench for bist_control: a March-table reference model predicts
// each cycle's outputs, a monitor pops and compares after every rising edge.
module tb_bist_control;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bist_control_if bus ();

    bist_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected output vector: {status,done,wr_en,read_en,rst_adr,pr_res_adr,enable,up_down,data_bit}
    logic [8:0] exp_q[$];

    // Reference model: the March algorithm as a list of operations per element.
    int nops  [5] = '{1, 2, 2, 2, 2};
    bit up    [5] = '{1, 1, 1, 0, 0};
    bit rdval [5] = '{0, 0, 1, 0, 1};
    bit wrval [5] = '{0, 1, 0, 1, 0};

    // mode: 0 idle, 1 element setup, 2 executing operation m_op, 3 finished
    int m_mode = 0;
    int m_elem = 0;
    int m_op   = 0;

    function automatic logic [8:0] dut_out();
        return {bus.status, bus.done, bus.wr_en, bus.read_en, bus.rst_adr,
                bus.pr_res_adr, bus.enable, bus.up_down, bus.data_bit};
    endfunction

    function automatic logic [8:0] model_out();
        logic [8:0] v;
        bit is_wr;
        v = '0;
        is_wr = (m_op == nops[m_elem] - 1);
        case (m_mode)
            1: v = {1'b1, 1'b0, 1'b0, 1'b0, up[m_elem], !up[m_elem], 1'b0, up[m_elem], 1'b0};
            2: if (is_wr) v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, up[m_elem], wrval[m_elem]};
               else       v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, up[m_elem], rdval[m_elem]};
            3: v = 9'b010000000;
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_step(input bit s, input bit c);
        case (m_mode)
            0, 3: if (s) begin m_mode = 1; m_elem = 0; m_op = 0; end
            1: begin m_mode = 2; m_op = 0; end
            2: begin
                if (m_op == nops[m_elem] - 1) begin
                    if (c) begin
                        if (m_elem == 4) m_mode = 3;
                        else begin m_elem++; m_mode = 1; end
                    end
                    m_op = 0;
                end else begin
                    m_op++;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic cycle(input bit s, input bit c);
        @(negedge clk);
        bus.start = s;
        bus.c_out = c;
        @(posedge clk);
        model_step(s, c);
        exp_q.push_back(model_out());
    endtask

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the scoreboard after every edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) check("scoreboard", dut_out(), exp_q.pop_front());
        end
    end

    initial begin
        int guard;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.c_out = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("reset_outputs", dut_out(), 9'b0);

        // Idle with start low.
        repeat (100) cycle(0, 0);

        // E0 for a few addresses, then c_out pulses step through elements.
        cycle(1, 0);
        repeat (5) cycle(0, 0);
        cycle(0, 1);
        repeat (6) cycle(0, 0);
        cycle(1, 0);            // start mid-run: ignored
        repeat (3) cycle(0, 0);

        // c_out held high: ignored in SETUP/RD, advances each WR until done.
        repeat (20) cycle(0, 1);
        repeat (3) cycle(0, 0);
        cycle(1, 0);            // restart from done
        repeat (4) cycle(0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++)
            cycle(($urandom % 8) == 0, ($urandom % 5) == 0);

        // Drive into E3, then assert reset asynchronously mid-element.
        guard = 0;
        cycle(1, 0);
        while (!(m_mode == 2 && m_elem == 3) && guard < 200) begin
            cycle(0, (m_mode == 2 && m_op == nops[m_elem] - 1) ? 1'b1 : 1'b0);
            guard++;
        end
        if (guard >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL reach_e3: got timeout expected element 3");
        end
        cycle(0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("async_reset_mid_e3", dut_out(), 9'b0);
        m_mode = 0; m_elem = 0; m_op = 0;
        @(posedge clk);
        #2 check("reset_held", dut_out(), 9'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) cycle(0, 0);
        cycle(1, 0);
        repeat (10) cycle(0, ($urandom % 3) == 0);

        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
